// File: rtl/dt_pack.sv
// rtl/dt_pack.sv - thresholds the 128x128 distance map and packs it into a 16-bit-per-word bitmap
module dt_pack #(
    parameter int PIX = 16384,
    parameter int WPB = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [7:0]  i_thr,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_res_rd,
    output logic [13:0] o_res_addr,
    input  logic [7:0]  i_res_di,
    output logic        o_sti_wr,
    output logic [9:0]  o_sti_addr,
    output logic [15:0] o_sti_do,
    output logic [14:0] o_obj_cnt
);

    localparam logic [13:0] LAST_PIX  = 14'(PIX - 1);
    localparam logic [9:0]  LAST_WORD = 10'(PIX / WPB - 1);
    localparam logic [3:0]  LAST_BIT  = 4'(WPB - 1);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_thr;
    logic        r_res_rd;
    logic [13:0] r_res_addr;
    logic        r_pix_v;
    logic [13:0] r_pix_idx;
    logic [15:0] r_shreg;
    logic        r_sti_wr;
    logic [9:0]  r_sti_addr;
    logic [15:0] r_sti_do;
    logic [14:0] r_obj_cnt;

    logic        w_start_ok;
    logic        w_last_rd;
    logic        w_last_wr;
    logic        w_bit;
    logic        w_word_end;
    logic [15:0] w_word;

    assign w_start_ok = (r_state == S_IDLE) && i_start;
    assign w_last_rd  = (r_state == S_READ) && (r_res_addr == LAST_PIX);
    assign w_last_wr  = r_sti_wr && (r_sti_addr == LAST_WORD);
    assign w_bit      = (i_res_di >= r_thr);
    assign w_word_end = r_pix_v && (r_pix_idx[3:0] == LAST_BIT);

    // Completed word includes the bit arriving this cycle, which is not yet in r_shreg.
    always_comb begin
        w_word = r_shreg;
        w_word[r_pix_idx[3:0]] = w_bit;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start)   w_next = S_READ;
            S_READ:  if (w_last_rd) w_next = S_DRAIN;
            S_DRAIN: if (w_last_wr) w_next = S_DONE;
            S_DONE:                 w_next = S_IDLE;
            default:                w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_thr      <= '0;
            r_res_rd   <= 1'b0;
            r_res_addr <= '0;
            r_pix_v    <= 1'b0;
            r_pix_idx  <= '0;
            r_shreg    <= '0;
            r_sti_wr   <= 1'b0;
            r_sti_addr <= '0;
            r_sti_do   <= '0;
            r_obj_cnt  <= '0;
        end else begin
            if (w_start_ok) begin
                r_thr      <= i_thr;
                r_res_rd   <= 1'b1;
                r_res_addr <= '0;
            end else if (r_state == S_READ) begin
                if (w_last_rd) begin
                    r_res_rd   <= 1'b0;
                    r_res_addr <= '0;
                end else begin
                    r_res_addr <= r_res_addr + 14'd1;
                end
            end

            // Read data lags the address by one cycle; this delay line tags it.
            r_pix_v   <= r_res_rd;
            r_pix_idx <= r_res_addr;

            if (r_pix_v) begin
                r_shreg[r_pix_idx[3:0]] <= w_bit;
            end

            r_sti_wr <= 1'b0;
            if (w_word_end) begin
                r_sti_wr   <= 1'b1;
                r_sti_addr <= r_pix_idx[13:4];
                r_sti_do   <= w_word;
            end

            if (w_start_ok) begin
                r_obj_cnt <= '0;
            end else if (r_pix_v && w_bit) begin
                r_obj_cnt <= r_obj_cnt + 15'd1;
            end
        end
    end

    assign o_busy     = (r_state != S_IDLE);
    assign o_done     = (r_state == S_DONE);
    assign o_res_rd   = r_res_rd;
    assign o_res_addr = r_res_addr;
    assign o_sti_wr   = r_sti_wr;
    assign o_sti_addr = r_sti_addr;
    assign o_sti_do   = r_sti_do;
    assign o_obj_cnt  = r_obj_cnt;

endmodule

// File: tb/tb_dt_pack.sv
// tb/tb_dt_pack.sv - scoreboard bench for dt_pack with directed maps and thresholds
module tb_dt_pack;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_start;
    logic [7:0]  i_thr;
    logic        o_busy;
    logic        o_done;
    logic        o_res_rd;
    logic [13:0] o_res_addr;
    logic [7:0]  i_res_di;
    logic        o_sti_wr;
    logic [9:0]  o_sti_addr;
    logic [15:0] o_sti_do;
    logic [14:0] o_obj_cnt;

    dt_pack #(.PIX(16384), .WPB(16)) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_start    (i_start),
        .i_thr      (i_thr),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_res_rd   (o_res_rd),
        .o_res_addr (o_res_addr),
        .i_res_di   (i_res_di),
        .o_sti_wr   (o_sti_wr),
        .o_sti_addr (o_sti_addr),
        .o_sti_do   (o_sti_do),
        .o_obj_cnt  (o_obj_cnt)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [9:0]  addr;
        logic [15:0] data;
    } wr_t;

    logic [7:0] mem [0:16383];
    wr_t        exp_q[$];
    int         cyc = 0;
    int         c0;
    int         n_checks = 0;
    int         n_fail = 0;
    int         n_wr;
    int         first_wr;
    int         rd_cnt;
    int         rd_err;
    logic [13:0] exp_raddr;

    always @(posedge i_clk) cyc <= cyc + 1;

    always @(posedge i_clk) begin
        if (o_res_rd) i_res_di <= mem[o_res_addr];
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Hand-derived bitmaps for the fixed maps; kind 3 evaluates the threshold rule over mem.
    function automatic logic [15:0] exp_word(input int kind, input int w, input logic [7:0] thr);
        logic [15:0] v;
        v = '0;
        case (kind)
            0: v = (w == 8) ? 16'h0004 : 16'h0000;
            1: v = ((w % 16) < 8) ? 16'h0000 : 16'hFFFF;
            2: v = 16'hFFFF;
            default: for (int b = 0; b < 16; b++) v[b] = (mem[16*w + b] >= thr);
        endcase
        return v;
    endfunction

    always @(negedge i_clk) begin
        if (o_sti_wr) begin
            wr_t e;
            n_wr++;
            if (first_wr < 0) first_wr = cyc;
            if (exp_q.size() == 0) begin
                check("stray_sti_wr", {22'd0, o_sti_addr}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("sti_addr", {22'd0, o_sti_addr}, {22'd0, e.addr});
                check("sti_do", {16'd0, o_sti_do}, {16'd0, e.data});
            end
        end
        if (o_res_rd) begin
            if (o_res_addr !== exp_raddr) rd_err++;
            exp_raddr = exp_raddr + 14'd1;
            rd_cnt++;
        end
    end

    // Pulses start in the current cycle (C0) and leaves the bench at C1.
    task automatic start_job(input logic [7:0] thr, input int kind);
        for (int w = 0; w < 1024; w++) exp_q.push_back({10'(w), exp_word(kind, w, thr)});
        n_wr = 0;
        first_wr = -1;
        rd_cnt = 0;
        rd_err = 0;
        exp_raddr = '0;
        i_start = 1'b1;
        i_thr = thr;
        c0 = cyc;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        i_thr = ~thr;
        check("busy_c1", {31'd0, o_busy}, 32'd1);
        check("res_rd_c1", {31'd0, o_res_rd}, 32'd1);
        check("obj_cnt_c1", {17'd0, o_obj_cnt}, 32'd0);
    endtask

    // Waits for done, checks the job, and leaves the bench at C16388.
    task automatic finish_job(input int dbl, input int exp_cnt);
        while (!o_done && (cyc - c0) < 17000) begin
            @(posedge i_clk); #1;
            i_start = (dbl != 0) && (cyc == c0 + 100);
        end
        check("done_seen", {31'd0, o_done}, 32'd1);
        check("done_cycle", cyc - c0, 32'd16387);
        check("busy_at_done", {31'd0, o_busy}, 32'd1);
        check("obj_cnt", {17'd0, o_obj_cnt}, exp_cnt);
        check("write_count", n_wr, 32'd1024);
        check("first_write_cycle", first_wr - c0, 32'd18);
        check("pending_writes", exp_q.size(), 32'd0);
        check("read_count", rd_cnt, 32'd16384);
        check("read_sequence_errors", rd_err, 32'd0);
        @(posedge i_clk); #1;
        check("busy_after_done", {31'd0, o_busy}, 32'd0);
        check("done_pulse_width", {31'd0, o_done}, 32'd0);
    endtask

    initial begin
        i_reset = 1'b0;
        i_start = 1'b0;
        i_thr = 8'd0;
        i_res_di = 8'd0;
        n_wr = 0;
        first_wr = -1;
        rd_cnt = 0;
        rd_err = 0;
        exp_raddr = '0;
        repeat (3) @(posedge i_clk);
        #1;
        check("reset_busy", {31'd0, o_busy}, 32'd0);
        check("reset_outputs", {o_done, o_res_rd, o_res_addr, o_sti_wr, o_sti_addr, o_sti_do},
              32'd0);
        check("reset_obj_cnt", {17'd0, o_obj_cnt}, 32'd0);
        i_reset = 1'b1;
        @(posedge i_clk); #1;

        // Single set pixel at 130 -> word 8 bit 2.
        for (int k = 0; k < 16384; k++) mem[k] = 8'd0;
        mem[130] = 8'd5;
        start_job(8'd1, 0);
        finish_job(0, 1);

        // Ramp map, aborted by reset at C5000 and then rerun in full.
        for (int k = 0; k < 16384; k++) mem[k] = 8'(k);
        start_job(8'd128, 1);
        repeat (4999) @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        @(posedge i_clk); #1;
        exp_q.delete();
        n_wr = 0;
        check("abort_busy", {31'd0, o_busy}, 32'd0);
        check("abort_outputs", {o_done, o_res_rd, o_res_addr, o_sti_wr, o_sti_addr, o_sti_do},
              32'd0);
        check("abort_obj_cnt", {17'd0, o_obj_cnt}, 32'd0);
        repeat (2) @(posedge i_clk);
        #1;
        i_reset = 1'b1;
        repeat (50) @(posedge i_clk);
        #1;
        check("writes_after_abort", n_wr, 32'd0);
        start_job(8'd128, 1);
        finish_job(0, 8192);

        // map = k mod 11: thr 0 with an ignored second start, then thr 1 and 6 back to back.
        for (int k = 0; k < 16384; k++) mem[k] = 8'(k % 11);
        start_job(8'd0, 2);
        finish_job(1, 16384);
        start_job(8'd1, 3);
        finish_job(0, 14894);
        start_job(8'd6, 3);
        finish_job(0, 7445);

        repeat (5) @(posedge i_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
